// File: rtl/spdif_pkg.sv
// Shared types and widths for the S/PDIF-to-I2S transmitter.
package spdif_pkg;

    localparam int unsigned SAMPLE_W   = 24;
    localparam int unsigned SLOT_W     = 32;
    localparam int unsigned SLOT_IDX_W = $clog2(SLOT_W);
    localparam int unsigned BIT_CNT_W  = SLOT_IDX_W + 1;

    typedef struct packed {
        logic [SAMPLE_W-1:0] left;
        logic [SAMPLE_W-1:0] right;
    } pair_t;

    // Serial bit for a slot position: one-BCLK delay, MSB at slot 1, zero padding after the LSB.
    function automatic logic slot_bit(input logic [SAMPLE_W-1:0] word,
                                      input logic [SLOT_IDX_W-1:0] slot);
        logic r_bit;
        r_bit = 1'b0;
        if (slot >= SLOT_IDX_W'(1) && slot <= SLOT_IDX_W'(SAMPLE_W))
            r_bit = word[SLOT_IDX_W'(SAMPLE_W) - slot];
        return r_bit;
    endfunction

endpackage

// File: rtl/spdif_pair_fifo.sv
// Synchronous stereo-pair FIFO; a push while full is accepted only alongside a pop.
module spdif_pair_fifo
    import spdif_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned LVL_W = PTR_W + 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  pair_t            i_push_data,
    input  logic             i_pop,
    output pair_t            o_pop_data_c,
    output logic             o_full_c,
    output logic             o_empty_c,
    output logic [LVL_W-1:0] o_level
);

    pair_t            r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_empty_c    = (r_level == '0);
    assign o_full_c     = (r_level == LVL_W'(DEPTH));
    assign w_pop_ok     = i_pop && !o_empty_c;
    assign w_push_ok    = i_push && (!o_full_c || w_pop_ok);
    assign o_pop_data_c = r_mem[r_rd_ptr];
    assign o_level      = r_level;

    always_ff @(posedge i_clk) begin
        if (w_push_ok)
            r_mem[r_wr_ptr] <= i_push_data;
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok)
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop_ok)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/spdif_i2s_tx.sv
// Pairs S/PDIF L/R samples, buffers them and serializes 64-BCLK I2S frames.
// Define SPDIF_I2S_HOLD_EN to replay the last popped pair on underrun instead of zeros.
module spdif_i2s_tx
    import spdif_pkg::*;
#(
    parameter  int unsigned BCLK_DIV   = 4,
    parameter  int unsigned FIFO_DEPTH = 4,
    localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                iClk,
    input  logic                iRst_n,
    input  logic [SAMPLE_W-1:0] iDataL,
    input  logic [SAMPLE_W-1:0] iDataR,
    input  logic                iDatavalidL,
    input  logic                iDatavalidR,
    output logic                oBclk,
    output logic                oLrclk,
    output logic                oSdata,
    output logic [LVL_W-1:0]    oFifoLevel,
    output logic                oUnderrun,
    output logic                oOverflow
);

    localparam int unsigned DIV_W = 8;

    logic [1:0]           r_rst_sync;
    logic                 w_rst_n;
    logic [SAMPLE_W-1:0]  r_pend_l;
    logic                 r_pend;
    logic                 w_push;
    pair_t                w_push_pair;
    logic [DIV_W-1:0]     r_div;
    logic                 r_bclk;
    logic [BIT_CNT_W-1:0] r_b;
    logic                 r_lrclk;
    logic                 r_sdata;
    logic                 r_underrun;
    logic                 r_overflow;
    pair_t                r_frame;
    logic                 w_wrap;
    logic                 w_fall;
    logic [BIT_CNT_W-1:0] w_b_nxt;
    logic                 w_frame_start;
    logic                 w_pop;
    pair_t                w_pop_pair;
    pair_t                w_fill_pair;
    logic                 w_full;
    logic                 w_empty;
    logic [SAMPLE_W-1:0]  w_word;

    // Assertion is immediate; release is delayed two clocks.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n)
            r_rst_sync <= '0;
        else
            r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    always_comb begin
        w_push            = 1'b0;
        w_push_pair.left  = iDataL;
        w_push_pair.right = iDataR;
        if (iDatavalidL && iDatavalidR) begin
            w_push = 1'b1;
        end else if (iDatavalidR && r_pend) begin
            w_push           = 1'b1;
            w_push_pair.left = r_pend_l;
        end
    end

    always_ff @(posedge iClk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_pend   <= 1'b0;
            r_pend_l <= '0;
        end else if (iDatavalidR) begin
            r_pend <= 1'b0;
        end else if (iDatavalidL) begin
            r_pend   <= 1'b1;
            r_pend_l <= iDataL;
        end
    end

    assign w_wrap        = (r_div == DIV_W'(BCLK_DIV - 1));
    assign w_fall        = w_wrap && r_bclk;
    assign w_b_nxt       = r_b + BIT_CNT_W'(1);
    assign w_frame_start = w_fall && (w_b_nxt == '0);
    assign w_pop         = w_frame_start && !w_empty;
    assign w_word        = w_b_nxt[BIT_CNT_W-1] ? r_frame.right : r_frame.left;

    spdif_pair_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk        (iClk),
        .i_rst_n      (w_rst_n),
        .i_push       (w_push),
        .i_push_data  (w_push_pair),
        .i_pop        (w_pop),
        .o_pop_data_c (w_pop_pair),
        .o_full_c     (w_full),
        .o_empty_c    (w_empty),
        .o_level      (oFifoLevel)
    );

`ifdef SPDIF_I2S_HOLD_EN
    pair_t r_hold;

    always_ff @(posedge iClk or negedge w_rst_n) begin
        if (!w_rst_n)
            r_hold <= '0;
        else if (w_pop)
            r_hold <= w_pop_pair;
    end
    assign w_fill_pair = r_hold;
`else
    assign w_fill_pair = '0;
`endif

    // Slot 0 always sends 0, so the old frame word is harmless on the frame-start edge.
    always_ff @(posedge iClk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_div      <= '0;
            r_bclk     <= 1'b0;
            r_b        <= '1;
            r_lrclk    <= 1'b0;
            r_sdata    <= 1'b0;
            r_underrun <= 1'b0;
            r_overflow <= 1'b0;
            r_frame    <= '0;
        end else begin
            r_underrun <= 1'b0;
            r_div      <= w_wrap ? '0 : r_div + DIV_W'(1);
            if (w_wrap)
                r_bclk <= ~r_bclk;
            if (w_fall) begin
                r_b     <= w_b_nxt;
                r_lrclk <= w_b_nxt[BIT_CNT_W-1];
                r_sdata <= slot_bit(w_word, w_b_nxt[SLOT_IDX_W-1:0]);
            end
            if (w_frame_start) begin
                r_frame    <= w_empty ? w_fill_pair : w_pop_pair;
                r_underrun <= w_empty;
            end
            if (w_push && w_full && !w_pop)
                r_overflow <= 1'b1;
        end
    end

    assign oBclk     = r_bclk;
    assign oLrclk    = r_lrclk;
    assign oSdata    = r_sdata;
    assign oUnderrun = r_underrun;
    assign oOverflow = r_overflow;

endmodule

// File: tb/tb_spdif_i2s_tx.sv
// Directed self-checking bench for spdif_i2s_tx; a negedge monitor decodes I2S frames.
module tb_spdif_i2s_tx;

    localparam int unsigned BCLK_DIV     = 8;
    localparam int unsigned FIFO_DEPTH   = 4;
    localparam int unsigned FRAME_BUDGET = 64 * 2 * BCLK_DIV + 256;
`ifdef SPDIF_I2S_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic        iClk = 1'b0;
    logic        iRst_n = 1'b0;
    logic [23:0] iDataL = '0;
    logic [23:0] iDataR = '0;
    logic        iDatavalidL = 1'b0;
    logic        iDatavalidR = 1'b0;
    logic        oBclk, oLrclk, oSdata, oUnderrun, oOverflow;
    logic [2:0]  oFifoLevel;

    int n_checks = 0;
    int n_fail   = 0;

    spdif_i2s_tx #(
        .BCLK_DIV   (BCLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .iClk        (iClk),
        .iRst_n      (iRst_n),
        .iDataL      (iDataL),
        .iDataR      (iDataR),
        .iDatavalidL (iDatavalidL),
        .iDatavalidR (iDatavalidR),
        .oBclk       (oBclk),
        .oLrclk      (oLrclk),
        .oSdata      (oSdata),
        .oFifoLevel  (oFifoLevel),
        .oUnderrun   (oUnderrun),
        .oOverflow   (oOverflow)
    );

    always #5 iClk = ~iClk;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Frame decoder: tracks the bit counter from reset and rebuilds each frame's words.
    logic [5:0]  tb_b;
    logic        prev_bclk, prev_sd, prev_lr;
    logic [23:0] cur_l, cur_r, last_l, last_r;
    int frame_cnt = 0, n_underrun = 0, lr_err = 0, pad_err = 0, edge_err = 0;
    int s;

    always @(negedge iClk) begin
        if (!iRst_n) begin
            tb_b = 6'd63; prev_bclk = 1'b0; prev_sd = 1'b0; prev_lr = 1'b0;
            cur_l = '0; cur_r = '0;
        end else begin
            if (prev_bclk && !oBclk) begin
                tb_b = tb_b + 6'd1;
                if (oLrclk !== tb_b[5]) lr_err++;
                s = int'(tb_b[4:0]);
                if (s >= 1 && s <= 24) begin
                    if (tb_b[5]) cur_r[24-s] = oSdata;
                    else         cur_l[24-s] = oSdata;
                end else if (oSdata !== 1'b0) begin
                    pad_err++;
                end
                if (tb_b == 6'd63) begin
                    last_l = cur_l; last_r = cur_r; frame_cnt++;
                end
            end else if (oSdata !== prev_sd || oLrclk !== prev_lr) begin
                edge_err++;
            end
            if (oUnderrun) n_underrun++;
            prev_bclk = oBclk; prev_sd = oSdata; prev_lr = oLrclk;
        end
    end

    function automatic logic [23:0] pl(input int k);
        return 24'(32'h010101 * k);
    endfunction
    function automatic logic [23:0] pr(input int k);
        return 24'(32'h800000 | k);
    endfunction

    task automatic strobe(input bit vl, input bit vr, input logic [23:0] l, input logic [23:0] r);
        iDataL = l; iDataR = r; iDatavalidL = vl; iDatavalidR = vr;
        @(negedge iClk);
        iDatavalidL = 1'b0; iDatavalidR = 1'b0;
    endtask

    // Returns on the negedge after the monitor closes a frame.
    task automatic wait_frame();
        int start;
        bit seen;
        start = frame_cnt;
        seen  = 1'b0;
        for (int i = 0; i < int'(FRAME_BUDGET) && !seen; i++) begin
            @(posedge iClk);
            if (frame_cnt != start) seen = 1'b1;
        end
        check_val("frame_timeout", 64'(seen), 64'd1);
        @(negedge iClk);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_val({tag, "_bclk"},  64'(oBclk), 64'd0);
        check_val({tag, "_lrclk"}, 64'(oLrclk), 64'd0);
        check_val({tag, "_sdata"}, 64'(oSdata), 64'd0);
        check_val({tag, "_level"}, 64'(oFifoLevel), 64'd0);
        check_val({tag, "_undr"},  64'(oUnderrun), 64'd0);
        check_val({tag, "_ovf"},   64'(oOverflow), 64'd0);
    endtask

    initial begin
        int u0;
        bit seen;

        repeat (3) @(negedge iClk);
        #1 check_outputs_zero("rst");
        @(negedge iClk);
        #2 iRst_n = 1'b1;
        repeat (3) @(negedge iClk);

        // First frame carries a split L/R pair
        strobe(1'b1, 1'b0, 24'hABCDEF, 24'h0);
        strobe(1'b0, 1'b1, 24'h0, 24'h123456);
        check_val("lvl_first", 64'(oFifoLevel), 64'd1);
        u0 = n_underrun;
        wait_frame();
        check_val("f1_left", 64'(last_l), 64'hABCDEF);
        check_val("f1_right", 64'(last_r), 64'h123456);
        check_val("f1_undr", 64'(n_underrun - u0), 64'd0);
        check_val("f1_level", 64'(oFifoLevel), 64'd0);

        // Three starved frames
        u0 = n_underrun;
        for (int i = 0; i < 3; i++) begin
            wait_frame();
            check_val("undr_left", 64'(last_l), HOLD ? 64'hABCDEF : 64'h0);
            check_val("undr_right", 64'(last_r), HOLD ? 64'h123456 : 64'h0);
        end
        check_val("undr_count", 64'(n_underrun - u0), 64'd3);

        // Six pushes into a depth-4 FIFO
        for (int k = 1; k <= 6; k++) strobe(1'b1, 1'b1, pl(k), pr(k));
        check_val("ovf_level", 64'(oFifoLevel), 64'd4);
        check_val("ovf_flag", 64'(oOverflow), 64'd1);
        u0 = n_underrun;
        for (int k = 1; k <= 4; k++) begin
            wait_frame();
            check_val("ovf_left", 64'(last_l), 64'(pl(k)));
            check_val("ovf_right", 64'(last_r), 64'(pr(k)));
        end
        wait_frame();
        check_val("ovf_tail_l", 64'(last_l), HOLD ? 64'(pl(4)) : 64'h0);
        check_val("ovf_tail_r", 64'(last_r), HOLD ? 64'(pr(4)) : 64'h0);
        check_val("ovf_undr", 64'(n_underrun - u0), 64'd1);
        check_val("ovf_sticky", 64'(oOverflow), 64'd1);

        // Simultaneous L/R strobe
        strobe(1'b1, 1'b1, 24'h000001, 24'h800000);
        check_val("both_level", 64'(oFifoLevel), 64'd1);
        u0 = n_underrun;
        wait_frame();
        check_val("both_left", 64'(last_l), 64'h000001);
        check_val("both_right", 64'(last_r), 64'h800000);
        check_val("both_undr", 64'(n_underrun - u0), 64'd0);

        // Orphan R, then L overwritten before its R
        strobe(1'b0, 1'b1, 24'h0, 24'h777777);
        check_val("orphan_r", 64'(oFifoLevel), 64'd0);
        strobe(1'b1, 1'b0, 24'h111111, 24'h0);
        strobe(1'b1, 1'b0, 24'h222222, 24'h0);
        strobe(1'b0, 1'b1, 24'h0, 24'h333333);
        check_val("pend_level", 64'(oFifoLevel), 64'd1);
        wait_frame();
        check_val("pend_left", 64'(last_l), 64'h222222);
        check_val("pend_right", 64'(last_r), 64'h333333);

        // Reset at b = 40 with data still queued
        strobe(1'b1, 1'b1, 24'h0A0A0A, 24'h0B0B0B);
        strobe(1'b1, 1'b1, 24'h0C0C0C, 24'h0D0D0D);
        seen = 1'b0;
        for (int i = 0; i < int'(FRAME_BUDGET) && !seen; i++) begin
            @(posedge iClk);
            if (tb_b == 6'd40) seen = 1'b1;
        end
        check_val("b40_timeout", 64'(seen), 64'd1);
        @(negedge iClk);
        #2 iRst_n = 1'b0;
        #1 check_outputs_zero("midrst");
        repeat (2) @(negedge iClk);
        #2 iRst_n = 1'b1;
        repeat (3) @(negedge iClk);
        strobe(1'b1, 1'b1, 24'h5A5A5A, 24'hA5A5A5);
        u0 = n_underrun;
        wait_frame();
        check_val("post_left", 64'(last_l), 64'h5A5A5A);
        check_val("post_right", 64'(last_r), 64'hA5A5A5);
        wait_frame();
        check_val("post_tail_l", 64'(last_l), HOLD ? 64'h5A5A5A : 64'h0);
        check_val("post_tail_r", 64'(last_r), HOLD ? 64'hA5A5A5 : 64'h0);
        check_val("post_undr", 64'(n_underrun - u0), 64'd1);

        // Fill, then push on exactly the frame-start pop edge (16 cycles after b = 63)
        for (int c = 1; c <= 15; c++) begin
            if (c <= 4) begin
                iDataL = 24'(32'h300000 | c); iDataR = 24'(32'h0C0000 | c);
                iDatavalidL = 1'b1; iDatavalidR = 1'b1;
            end else if (c == 15) begin
                iDataL = 24'h300005; iDataR = 24'h0C0005;
                iDatavalidL = 1'b1; iDatavalidR = 1'b1;
            end else begin
                iDatavalidL = 1'b0; iDatavalidR = 1'b0;
            end
            if (c == 6) check_val("align_full", 64'(oFifoLevel), 64'd4);
            @(negedge iClk);
        end
        iDatavalidL = 1'b0; iDatavalidR = 1'b0;
        check_val("align_level", 64'(oFifoLevel), 64'd4);
        check_val("align_ovf", 64'(oOverflow), 64'd0);
        u0 = n_underrun;
        for (int k = 1; k <= 5; k++) begin
            wait_frame();
            check_val("align_left", 64'(last_l), 64'(32'h300000 | k));
            check_val("align_right", 64'(last_r), 64'(32'h0C0000 | k));
        end
        check_val("align_undr", 64'(n_underrun - u0), 64'd0);

        check_val("lrclk_align", 64'(lr_err), 64'd0);
        check_val("slot_padding", 64'(pad_err), 64'd0);
        check_val("change_on_fall", 64'(edge_err), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spdif_i2s_tx.md
SPDIF_I2S_TX -- requirements
Module: spdif_i2s_tx

Interface
REQ-001 Parameter BCLK_DIV, default 4: iClk cycles per BCLK half-period; legal values are 2 to 255.
REQ-002 Parameter FIFO_DEPTH, default 4: stereo-pair FIFO depth; must be a power of 2, from 2 to 16.
REQ-003 iClk  in  1  sole clock; all logic is rising-edge.
REQ-004 iRst_n  in  1  asynchronous, active-low reset.
REQ-005 iDataL  in  24  left sample from the S/PDIF receiver.
REQ-006 iDataR  in  24  right sample from the S/PDIF receiver.
REQ-007 iDatavalidL  in  1  one-cycle strobe qualifying iDataL.
REQ-008 iDatavalidR  in  1  one-cycle strobe qualifying iDataR.
REQ-009 oBclk  out  1  I2S bit clock.
REQ-010 oLrclk  out  1  I2S word select; 0 = left, 1 = right.
REQ-011 oSdata  out  1  I2S serial data, MSB first.
REQ-012 oFifoLevel  out  $clog2(FIFO_DEPTH)+1  number of stored pairs.
REQ-013 oUnderrun  out  1  one-cycle pulse when a frame starts with the FIFO empty.
REQ-014 oOverflow  out  1  sticky flag: a pair was dropped; cleared only by reset.

Function
REQ-015 Pairing: iDatavalidL shall latch iDataL into a pending register and set a pend flag.
- A second L strobe while pend is set overwrites the pending value.
REQ-016 iDatavalidR with pend set shall push {pendL, iDataR} and clear pend.
- iDatavalidR with pend clear is discarded.
REQ-017 L and R strobes in the same cycle shall push {iDataL, iDataR} directly and leave pend clear.
REQ-018 A push while the FIFO is full shall be dropped and set oOverflow.
- Exception: if a pop occurs in the same cycle, the push is accepted and the level is unchanged.
REQ-019 BCLK generator: a divider counter 0..BCLK_DIV-1 shall toggle oBclk at each wrap.
- oBclk idles low.
- The falling-edge event is the cycle in which oBclk goes 1->0.
REQ-020 A 6-bit bit counter b shall increment on each falling-edge event and wrap from 63 to 0.
- oLrclk = b[5].
REQ-021 On the falling-edge event where b wraps to 0, the frame-start logic shall act as follows:
- FIFO non-empty: pop one pair into the frame register.
- FIFO empty: pulse oUnderrun and load the underrun pair (see REQ-030/031).
REQ-022 Slot bit s = b[4:0]. oSdata per slot:
- s = 0: 0 (I2S one-BCLK delay).
- s = 1..24: sample bit 24-s, so MSB at s = 1.
- s = 25..31: 0.
- Left slot uses the left word; right slot uses the right word.
REQ-023 oSdata and oLrclk shall change only on falling-edge events, in the same iClk cycle as oBclk falls.
REQ-024 Latency: a pair pushed into an empty FIFO appears at the next frame start.
- Its MSB is driven at b = 1.
REQ-025 A pop and a push in the same cycle shall both take effect.
- Pointers wrap modulo FIFO_DEPTH.

Reset
REQ-026 On iRst_n low, immediately and without a clock, the following shall be set:
- oBclk = 0, oLrclk = 0, oSdata = 0, oFifoLevel = 0, oUnderrun = 0, oOverflow = 0.
- Divider counter = 0, b = 63, pend = 0, frame register = 0, hold register = 0.
REQ-027 Reset asserted mid-frame shall abort the frame and discard FIFO contents.
REQ-028 After reset release, the first falling-edge event brings b to 0 and starts a frame.
REQ-029 Reset deassertion shall be synchronized internally (two-flop release) before the logic leaves reset.

Configuration
REQ-030 With macro SPDIF_I2S_HOLD_EN defined, underrun shall replay the last popped pair (hold register; zeros until the first pop).
REQ-031 Without SPDIF_I2S_HOLD_EN, underrun shall transmit zeros and no hold register is built.
- oUnderrun behaves identically in both builds.

Structure
REQ-032 Shared package spdif_pkg shall hold:
- SAMPLE_W = 24, SLOT_W = 32.
- The stereo-pair struct {left, right}.
REQ-033 One sub-module, spdif_pair_fifo, shall implement the synchronous stereo-pair FIFO with push, pop, full, empty and level.
- The serializer, divider and pairing logic stay in the top level.

Verification
REQ-034 Reset, then L = 0xABCDEF and R = 0x123456 pushed before b = 0:
- Left slot s = 1..24 carries 0xABCDEF MSB first.
- Right slot carries 0x123456.
- oLrclk falls 1 BCLK before the left MSB.
REQ-035 No pushes for 3 frames:
- 3 oUnderrun pulses.
- oSdata stays 0 without SPDIF_I2S_HOLD_EN.
- With SPDIF_I2S_HOLD_EN, the last pair repeats.
REQ-036 Push 6 pairs with no pop and FIFO_DEPTH = 4:
- oFifoLevel = 4 and oOverflow = 1.
- Pairs 5 and 6 are absent from the output.
REQ-037 L and R strobes in the same cycle with 0x000001 / 0x800000:
- One push.
- The left LSB is at s = 24 and the right MSB is at s = 1.
REQ-038 Push aligned to the frame-start pop while full:
- The level stays 4 and oOverflow stays 0.
REQ-039 R strobe without a preceding L: no push.
REQ-040 iRst_n low at b = 40:
- All outputs are 0 in the same cycle.
- The first frame after release reflects only new pushes.
